// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and width helpers for the UART receive path.
// UART_RX_BREAK_DETECT_EN adds the BREAK_WAIT state.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
`ifdef UART_RX_BREAK_DETECT_EN
        , ST_BREAK_WAIT
`endif
    } rx_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit clock counter and 3-sample majority vote around
// bit centre. The counter is held at zero while clear is asserted.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic clear,
    output logic rx_s,
    output logic sample_valid,
    output logic bit_val,
    output logic bit_end
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned C  = CLKS_PER_BIT / 2;

    logic          sync1;
    logic [CW-1:0] cnt;
    logic          s0;
    logic          s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            cnt   <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            if (clear || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (cnt == CW'(C - 1))
                s0 <= rx_s;
            if (cnt == CW'(C))
                s1 <= rx_s;
        end
    end

    // Third sample is taken live at C+1 so the vote is available in that cycle.
    assign sample_valid = (cnt == CW'(C + 1));
    assign bit_val      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign bit_end      = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_framer.sv
// Parametrised UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Define UART_RX_BREAK_DETECT_EN to add o_Break and the BREAK_WAIT state.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Rx_Data,
    output logic                 o_Rx_Done,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_Break,
`endif
    output logic                 o_Busy
);

    localparam int unsigned IW = cnt_width(DATA_BITS);

    rx_state_t              state;
    rx_state_t              state_n;
    logic                   rx_s;
    logic                   sample_valid;
    logic                   bit_val;
    logic                   bit_end;
    logic                   cnt_clear;
    logic [DATA_BITS-1:0]   shreg;
    logic [IW-1:0]          idx;
    logic                   stop_idx;
    logic                   last_stop;
    logic                   par_err_r;
    logic                   par_expect;
    logic                   frame_acc;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   par_zero;
    logic                   brk_r;
    logic                   brk_now;
`endif

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk         (clk),
        .reset       (reset),
        .rx          (i_Rx_Data),
        .clear       (cnt_clear),
        .rx_s        (rx_s),
        .sample_valid(sample_valid),
        .bit_val     (bit_val),
        .bit_end     (bit_end)
    );

    assign last_stop  = (STOP_BITS == 2) ? stop_idx : 1'b1;
    assign par_expect = (PARITY_MODE == PAR_EVEN) ? ^shreg : ~^shreg;
`ifdef UART_RX_BREAK_DETECT_EN
    assign brk_now = stop_idx ? brk_r : ((shreg == '0) && par_zero && !bit_val);
`endif

    always_comb begin
        state_n   = state;
        cnt_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_s)
                    state_n = ST_START;
            end
            ST_START: begin
                if (sample_valid && bit_val)
                    state_n = ST_IDLE;
                else if (bit_end)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && idx == IW'(DATA_BITS - 1))
                    state_n = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end)
                    state_n = ST_STOP;
            end
            // Leave on the last stop sample rather than at bit end so a following
            // start edge is never missed.
            ST_STOP: begin
                if (sample_valid && last_stop)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                cnt_clear = 1'b1;
                state_n   = ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                if (brk_r)
                    state_n = ST_BREAK_WAIT;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            ST_BREAK_WAIT: begin
                cnt_clear = !rx_s;
                if (rx_s && bit_end)
                    state_n = ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            idx          <= '0;
            stop_idx     <= 1'b0;
            par_err_r    <= 1'b0;
            frame_acc    <= 1'b0;
            o_Rx_Done    <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_zero     <= 1'b1;
            brk_r        <= 1'b0;
            o_Break      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            o_Busy    <= (state_n != ST_IDLE);
            o_Rx_Done <= (state_n == ST_DONE);
            case (state)
                ST_IDLE: begin
                    idx       <= '0;
                    stop_idx  <= 1'b0;
                    par_err_r <= 1'b0;
                    frame_acc <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_zero  <= 1'b1;
                    brk_r     <= 1'b0;
`endif
                end
                ST_DATA: begin
                    if (sample_valid)
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (bit_end)
                        idx <= idx + 1'b1;
                end
                ST_PARITY: begin
                    if (sample_valid) begin
                        par_err_r <= bit_val ^ par_expect;
`ifdef UART_RX_BREAK_DETECT_EN
                        par_zero  <= !bit_val;
`endif
                    end
                end
                ST_STOP: begin
                    if (sample_valid) begin
                        if (!bit_val)
                            frame_acc <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (!stop_idx)
                            brk_r <= brk_now;
`endif
                    end
                    if (bit_end)
                        stop_idx <= 1'b1;
                end
                default: ;
            endcase
            if (state_n == ST_DONE) begin
                o_Rx_Byte    <= shreg;
                o_Parity_Err <= par_err_r;
                o_Frame_Err  <= frame_acc | !bit_val;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            o_Break <= (state_n == ST_DONE) && brk_now;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: an 8E1 and a 7N2 instance, CLKS_PER_BIT=16.
// Break-detect vectors run when UART_RX_BREAK_DETECT_EN is defined.
module tb_uart_rx_framer;

    localparam int unsigned CPB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;

    always #5 clk = ~clk;

    logic       done_a, perr_a, ferr_a, busy_a;
    logic [7:0] byte_a;
    logic       done_b, perr_b, ferr_b, busy_b;
    logic [6:0] byte_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_a, brk_b;
`endif

    uart_rx_framer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .i_Rx_Data   (rx_a),
        .o_Rx_Done   (done_a),
        .o_Rx_Byte   (byte_a),
        .o_Parity_Err(perr_a),
        .o_Frame_Err (ferr_a),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break     (brk_a),
`endif
        .o_Busy      (busy_a)
    );

    uart_rx_framer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (7),
        .PARITY_MODE (0),
        .STOP_BITS   (2)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .i_Rx_Data   (rx_b),
        .o_Rx_Done   (done_b),
        .o_Rx_Byte   (byte_b),
        .o_Parity_Err(perr_b),
        .o_Frame_Err (ferr_b),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break     (brk_b),
`endif
        .o_Busy      (busy_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_done_a    = 0;
    int n_done_b    = 0;
    int done_cyc_a  = 0;
    int done_cyc_b  = 0;
    int t_start     = 0;
    int n_brk_a     = 0;
    int n_brk_b     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) begin
            n_done_a   <= n_done_a + 1;
            done_cyc_a <= cyc;
        end
        if (done_b) begin
            n_done_b   <= n_done_b + 1;
            done_cyc_b <= cyc;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_a) n_brk_a <= n_brk_a + 1;
        if (brk_b) n_brk_b <= n_brk_b + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits[0] is the start bit; one line bit per CPB cycles, optional one-cycle inversion.
    task automatic send(input bit sel, input logic [15:0] bits, input int nbits, input int glitch_n);
        for (int n = 0; n < nbits * CPB; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) t_start = cyc;
            if (sel) rx_b = bits[n / CPB] ^ (n == glitch_n);
            else     rx_a = bits[n / CPB] ^ (n == glitch_n);
        end
        @(posedge clk);
        #1;
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
    endtask

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic par);
        return {5'b0, 1'b1, par, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7n2(input logic [6:0] d, input logic stop2);
        return {6'b0, stop2, 1'b1, d, 1'b0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_done_a", {31'b0, done_a}, 0);
        check("rst_byte_a", {24'b0, byte_a}, 0);
        check("rst_perr_a", {31'b0, perr_a}, 0);
        check("rst_ferr_a", {31'b0, ferr_a}, 0);
        check("rst_busy_a", {31'b0, busy_a}, 0);
        check("rst_busy_b", {31'b0, busy_b}, 0);
        reset = 1'b0;
        idle(5);

        // 8E1 0xA5, correct parity 0; done 173 cycles after the start edge
        send(0, f8e1(8'hA5, 1'b0), 11, -1);
        idle(20);
        check("a5_count", n_done_a, 1);
        check("a5_byte", {24'b0, byte_a}, 32'hA5);
        check("a5_perr", {31'b0, perr_a}, 0);
        check("a5_ferr", {31'b0, ferr_a}, 0);
        check("a5_latency", done_cyc_a - t_start, 173);

        // 8E1 0x3C with wrong parity bit
        send(0, f8e1(8'h3C, 1'b1), 11, -1);
        idle(20);
        check("3c_count", n_done_a, 2);
        check("3c_byte", {24'b0, byte_a}, 32'h3C);
        check("3c_perr", {31'b0, perr_a}, 1);
        check("3c_ferr", {31'b0, ferr_a}, 0);

        // 7N2 0x55 with second stop bit low, then a clean 0x2A
        send(1, f7n2(7'h55, 1'b0), 10, -1);
        idle(30);
        check("55_count", n_done_b, 1);
        check("55_byte", {25'b0, byte_b}, 32'h55);
        check("55_ferr", {31'b0, ferr_b}, 1);
        check("55_perr", {31'b0, perr_b}, 0);
        send(1, f7n2(7'h2A, 1'b1), 10, -1);
        idle(20);
        check("2a_count", n_done_b, 2);
        check("2a_byte", {25'b0, byte_b}, 32'h2A);
        check("2a_ferr", {31'b0, ferr_b}, 0);
        check("2a_latency", done_cyc_b - t_start, 157);

        // Start glitch: 4 low cycles
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        idle(4);
        rx_a = 1'b1;
        check("glitch_busy_hi", {31'b0, busy_a}, 1);
        begin
            int waited = 4;
            while (busy_a && waited < 16) begin
                idle(1);
                waited++;
            end
        end
        check("glitch_busy_lo", {31'b0, busy_a}, 0);
        idle(20);
        check("glitch_count", n_done_a, 2);

        // One-cycle inversion at sample C of data bit 3 (line cycle 9 + 16*4)
        send(0, f8e1(8'hF0, 1'b0), 11, 73);
        idle(20);
        check("noise_count", n_done_a, 3);
        check("noise_byte", {24'b0, byte_a}, 32'hF0);
        check("noise_perr", {31'b0, perr_a}, 0);

        // Back-to-back frames
        send(0, f8e1(8'h12, 1'b0), 11, -1);
        send(0, f8e1(8'h34, 1'b1), 11, -1);
        idle(20);
        check("b2b_count", n_done_a, 5);
        check("b2b_byte", {24'b0, byte_a}, 32'h34);
        check("b2b_perr", {31'b0, perr_a}, 0);

        // Reset after start + 4 data bits, then a full 0x81
        send(0, f8e1(8'hFF, 1'b0), 5, -1);
        reset = 1'b1;
        idle(2);
        check("midrst_byte", {24'b0, byte_a}, 0);
        check("midrst_busy", {31'b0, busy_a}, 0);
        reset = 1'b0;
        idle(20);
        check("midrst_count", n_done_a, 5);
        send(0, f8e1(8'h81, 1'b0), 11, -1);
        idle(20);
        check("81_count", n_done_a, 6);
        check("81_byte", {24'b0, byte_a}, 32'h81);
        check("81_ferr", {31'b0, ferr_a}, 0);

`ifdef UART_RX_BREAK_DETECT_EN
        // Line low for 20 bit times
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        idle(20 * CPB);
        rx_a = 1'b1;
        idle(60);
        check("brk_count", n_done_a, 7);
        check("brk_pulses", n_brk_a, 1);
        check("brk_ferr", {31'b0, ferr_a}, 1);
        check("brk_byte", {24'b0, byte_a}, 0);
        send(0, f8e1(8'hA5, 1'b0), 11, -1);
        idle(20);
        check("post_brk_count", n_done_a, 8);
        check("post_brk_byte", {24'b0, byte_a}, 32'hA5);
        check("post_brk_pulses", n_brk_a, 1);
        check("brk_b_pulses", n_brk_b, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
